bloom_sram_arbiter: RTL
=======================

# bloom_sram_arbiter

Ordered SRAM command scheduler placed directly downstream of the Bloom filter's counter-aging engine. It accepts that engine's independent read and write request pulses and merges them into one in-order command queue. It issues the commands on a single pipelined SRAM port with fixed read latency, and returns read data with a valid strobe. Read-modify-write sequences on Bloom buckets stay correctly ordered, and the filter's request pulses are decoupled from SRAM stalls.

## Interface
- DATA_WIDTH, 64, SRAM word width
- SRAM_ADDR_WIDTH, 19, SRAM word address width
- CMD_DEPTH_BITS, 3, log2 of command queue depth (8 entries)
- RD_LATENCY, 3, cycles from accepted read to `sram_rd_data` valid; range 1..8
- NEARLY_FULL_MARGIN, 2, free-slot threshold for `cmd_nearly_full`
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rd_0_req  in  1  one-cycle read request pulse
- rd_0_addr  in  SRAM_ADDR_WIDTH  read address, sampled with `rd_0_req`
- rd_0_ack  out  1  pulse: a read was accepted by SRAM
- rd_0_data  out  DATA_WIDTH  read data
- rd_0_vld  out  1  one-cycle strobe qualifying `rd_0_data`
- wr_0_req  in  1  one-cycle write request pulse
- wr_0_addr  in  SRAM_ADDR_WIDTH  write address
- wr_0_data  in  DATA_WIDTH  write data
- wr_0_ack  out  1  pulse: a write was accepted by SRAM
- cmd_nearly_full  out  1  free entries <= NEARLY_FULL_MARGIN
- overflow  out  1  sticky flag: a request was dropped
- sram_req  out  1  command valid
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  SRAM_ADDR_WIDTH  command address
- sram_wr_data  out  DATA_WIDTH  write data
- sram_rdy  in  1  SRAM accepts a command this cycle
- sram_rd_data  in  DATA_WIDTH  read return data

## Operation
- **Enqueue.** Each cycle, a `wr_0_req` entry is enqueued first, then a `rd_0_req` entry.
  - The queue accepts up to 2 pushes and 1 pop per cycle.
  - A write always precedes a same-cycle read, because the write carries older data.
- **Full queue.** Entries are enqueued in write-then-read order while free slots remain.
  - Any entry that does not fit is dropped and sets `overflow`.
  - `overflow` clears only on reset.
- **Output slot.** A single output register holds the command presented on `sram_*`.
  - The slot loads from the queue head when it is empty, or when its current command transfers in the same cycle.
  - A transfer is a cycle with `sram_req && sram_rdy`.
  - While `sram_req && !sram_rdy`, the outputs hold stable.
- **Issue order.** Commands issue strictly in arrival order; no reordering and no address comparison.
- **Read-return pipeline.** A shift register of RD_LATENCY+1 valid bits tracks accepted reads.
  - `sram_rd_data` is captured RD_LATENCY cycles after the transfer cycle.
  - The captured data is presented on `rd_0_data` together with `rd_0_vld`.
- **Occupancy.** Tracked by a CMD_DEPTH_BITS+1 bit counter: `next = occ + pushes - pop`. Pointers wrap modulo the depth.
- **Reset values.** All outputs are 0 at reset, including `rd_0_data` and `sram_wr_data`. The queue is empty and the valid pipeline is cleared.
- **Reset mid-operation.** In-flight reads are discarded; no `rd_0_vld` is produced for them.

## Timing
- A request sampled in cycle N appears on `sram_req` in cycle N+2 at the earliest, with an empty queue and `sram_rdy=1`.
- `rd_0_ack` / `wr_0_ack` assert in cycle T+1 for a transfer in cycle T, for one cycle.
- `rd_0_vld` asserts in cycle T+RD_LATENCY+1.
- Back-to-back transfers run at one per cycle when `sram_rdy` is held high.
- `cmd_nearly_full` is registered and reflects the occupancy at the end of the previous cycle.
- Upstream must stop issuing requests within NEARLY_FULL_MARGIN/2 cycles of `cmd_nearly_full` asserting.

## Configuration
- **BLOOM_SRAM_STATS_EN**
  - When defined, the block adds outputs `rd_count`, `wr_count` and `drop_count`, each 32 bits.
    - `rd_count` and `wr_count` increment on each transfer of their type.
    - `drop_count` increments by the number of entries dropped per cycle (0–2).
    - All three saturate at all-ones and reset to 0.
  - When undefined, these ports and their counters are absent; the rest of the behaviour is identical.

## Structure
- Shared package `bloom_sram_pkg` holds:
  - the command typedef {we, addr, data};
  - the opcode constants CMD_RD=0 and CMD_WR=1;
  - the default widths.
- Sub-module `bloom_sram_cmd_fifo` is a dual-push, single-pop circular buffer with occupancy and free-slot outputs. The arbiter instantiates it once.

## Test plan
- **Single read.** `rd_0_req` at addr 0x10 with `sram_rdy=1` and `sram_rd_data` = 0xA5A5 at the required cycle -> `sram_req`/`we=0` at N+2, `rd_0_ack` at N+3, `rd_0_vld` with 0xA5A5 at N+3+RD_LATENCY.
- **Simultaneous requests.** `wr_0_req` to addr 5 with data 0x1 and `rd_0_req` to addr 5 in the same cycle -> the write issues first, the read one cycle later; the SRAM model returns 0x1.
- **Stall.** Hold `sram_rdy=0` for 4 cycles with 3 commands queued -> `sram_*` stays stable, no acks; after release, 3 transfers on 3 consecutive cycles in order.
- **Overflow.** With 7 of 8 entries occupied, issue a write and a read together -> the write is enqueued, the read is dropped, `overflow`=1, and `drop_count`=1 with stats enabled.
- **Reset during reads.** Assert reset 1 cycle after 2 reads transfer -> no `rd_0_vld` ever appears; all outputs read 0 in the cycle after reset.
- **Throughput.** 6 alternating read/write pulses with `sram_rdy=1` -> 6 transfers on consecutive cycles, `cmd_nearly_full` never asserts.

Source files
------------

// File: rtl/bloom_sram_pkg.sv
// Shared command types and default widths for the Bloom filter SRAM arbiter.
package bloom_sram_pkg;

    localparam int unsigned DATA_WIDTH             = 64;
    localparam int unsigned SRAM_ADDR_WIDTH        = 19;
    localparam int unsigned CMD_DEPTH_BITS_DEF     = 3;
    localparam int unsigned RD_LATENCY_DEF         = 3;
    localparam int unsigned NEARLY_FULL_MARGIN_DEF = 2;
    localparam int unsigned CMD_W                  = 1 + SRAM_ADDR_WIDTH + DATA_WIDTH;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      data;
    } sram_cmd_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/bloom_sram_cmd_fifo.sv
// Dual-push, single-pop circular command buffer with occupancy, free-slot and
// registered nearly-full outputs. Push enables must already respect free_c.
module bloom_sram_cmd_fifo
    import bloom_sram_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = CMD_DEPTH_BITS_DEF,
    parameter int unsigned NF_MARGIN  = NEARLY_FULL_MARGIN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push0_en,
    input  logic [CMD_W-1:0]    push0_cmd,
    input  logic                push1_en,
    input  logic [CMD_W-1:0]    push1_cmd,
    input  logic                pop_en,
    output logic [CMD_W-1:0]    head_c,
    output logic [DEPTH_BITS:0] occ,
    output logic [DEPTH_BITS:0] free_c,
    output logic                nearly_full
);

    localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
    localparam int unsigned OCC_W = DEPTH_BITS + 1;
    localparam logic [OCC_W-1:0] DEPTH_W = OCC_W'(DEPTH);

    sram_cmd_t               mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic [OCC_W-1:0]        occ_nxt_c;
    logic                    pop_c;

    assign pop_c     = pop_en && (occ != '0);
    assign head_c    = mem[rd_ptr];
    assign free_c    = DEPTH_W - occ;
    assign occ_nxt_c = occ + OCC_W'(push0_en) + OCC_W'(push1_en) - OCC_W'(pop_c);

    // The second push lands behind the first when both occur in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            nearly_full <= 1'b0;
        end else begin
            if (push0_en) mem[wr_ptr] <= push0_cmd;
            if (push1_en) mem[wr_ptr + DEPTH_BITS'(push0_en)] <= push1_cmd;
            wr_ptr      <= wr_ptr + DEPTH_BITS'(push0_en) + DEPTH_BITS'(push1_en);
            if (pop_c) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            occ         <= occ_nxt_c;
            nearly_full <= (DEPTH_W - occ_nxt_c) <= OCC_W'(NF_MARGIN);
        end
    end

endmodule

// File: rtl/bloom_sram_arbiter.sv
// In-order SRAM command scheduler merging Bloom read/write pulses onto one port.
// Optional BLOOM_SRAM_STATS_EN adds saturating rd/wr/drop counters.
module bloom_sram_arbiter
    import bloom_sram_pkg::*;
#(
    parameter int unsigned CMD_DEPTH_BITS     = CMD_DEPTH_BITS_DEF,
    parameter int unsigned RD_LATENCY         = RD_LATENCY_DEF,
    parameter int unsigned NEARLY_FULL_MARGIN = NEARLY_FULL_MARGIN_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
    output logic                       rd_0_ack,
    output logic [DATA_WIDTH-1:0]      rd_0_data,
    output logic                       rd_0_vld,
    input  logic                       wr_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
    input  logic [DATA_WIDTH-1:0]      wr_0_data,
    output logic                       wr_0_ack,
    output logic                       cmd_nearly_full,
    output logic                       overflow,
    output logic                       sram_req,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wr_data,
    input  logic                       sram_rdy,
    input  logic [DATA_WIDTH-1:0]      sram_rd_data
`ifdef BLOOM_SRAM_STATS_EN
    ,
    output logic [31:0]                rd_count,
    output logic [31:0]                wr_count,
    output logic [31:0]                drop_count
`endif
);

    localparam int unsigned OCC_W = CMD_DEPTH_BITS + 1;

    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  free_c;
    logic [CMD_W-1:0]  head_c;
    sram_cmd_t         slot_cmd;
    slot_state_t       slot_state;
    slot_state_t       slot_state_nxt;
    logic              slot_load_c;
    logic              fifo_has_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              xfer_c;
    logic [1:0]        drops_c;
    logic [RD_LATENCY:0] rd_pipe;

    // Write claims a free slot before the same-cycle read.
    assign wr_acc_c   = wr_0_req && (free_c != '0);
    assign rd_acc_c   = rd_0_req && (free_c > OCC_W'(wr_acc_c));
    assign drops_c    = 2'(wr_0_req && !wr_acc_c) + 2'(rd_0_req && !rd_acc_c);
    assign fifo_has_c = (occ != '0);
    assign xfer_c     = (slot_state == SLOT_FULL) && sram_rdy;

    bloom_sram_cmd_fifo #(
        .DEPTH_BITS (CMD_DEPTH_BITS),
        .NF_MARGIN  (NEARLY_FULL_MARGIN)
    ) u_cmd_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0_en    (wr_acc_c),
        .push0_cmd   ({CMD_WR, wr_0_addr, wr_0_data}),
        .push1_en    (rd_acc_c),
        .push1_cmd   ({CMD_RD, rd_0_addr, DATA_WIDTH'(0)}),
        .pop_en      (slot_load_c),
        .head_c      (head_c),
        .occ         (occ),
        .free_c      (free_c),
        .nearly_full (cmd_nearly_full)
    );

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (!reset) slot_state <= SLOT_EMPTY;
        else        slot_state <= slot_state_nxt;
    end

    always_comb begin
        slot_state_nxt = slot_state;
        case (slot_state)
            SLOT_EMPTY: if (fifo_has_c)            slot_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (xfer_c && !fifo_has_c) slot_state_nxt = SLOT_EMPTY;
            default:                               slot_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Refill from the queue head when empty or when the current command leaves.
    always_comb begin
        slot_load_c = 1'b0;
        case (slot_state)
            SLOT_EMPTY: slot_load_c = fifo_has_c;
            SLOT_FULL:  slot_load_c = xfer_c && fifo_has_c;
            default:    slot_load_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)           slot_cmd <= '0;
        else if (slot_load_c) slot_cmd <= sram_cmd_t'(head_c);
    end

    assign sram_req     = (slot_state == SLOT_FULL);
    assign sram_we      = slot_cmd.we;
    assign sram_addr    = slot_cmd.addr;
    assign sram_wr_data = slot_cmd.data;

    // Bit k of rd_pipe is set k+1 cycles after a read transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_0_ack  <= 1'b0;
            wr_0_ack  <= 1'b0;
            rd_pipe   <= '0;
            rd_0_data <= '0;
            overflow  <= 1'b0;
        end else begin
            rd_0_ack <= xfer_c && (slot_cmd.we == CMD_RD);
            wr_0_ack <= xfer_c && (slot_cmd.we == CMD_WR);
            rd_pipe  <= {rd_pipe[RD_LATENCY-1:0], xfer_c && (slot_cmd.we == CMD_RD)};
            if (rd_pipe[RD_LATENCY-1]) rd_0_data <= sram_rd_data;
            if (drops_c != 2'd0)       overflow  <= 1'b1;
        end
    end

    assign rd_0_vld = rd_pipe[RD_LATENCY];

`ifdef BLOOM_SRAM_STATS_EN
    logic [32:0] drop_sum_c;

    assign drop_sum_c = {1'b0, drop_count} + 33'(drops_c);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count   <= '0;
            wr_count   <= '0;
            drop_count <= '0;
        end else begin
            if (xfer_c && (slot_cmd.we == CMD_RD) && (rd_count != '1)) rd_count <= rd_count + 32'd1;
            if (xfer_c && (slot_cmd.we == CMD_WR) && (wr_count != '1)) wr_count <= wr_count + 32'd1;
            drop_count <= drop_sum_c[32] ? '1 : drop_sum_c[31:0];
        end
    end
`endif

endmodule
